// File: rtl/serial_prog_loader.sv
// serial_prog_loader
//   Bit-serial loader feeding the io_interface load port. A host shifts
//   16-bit words in MSB first while ser_frame is high. The first word of a
//   frame is a header selecting the target memory (bit W-1: 1=instr,
//   0=data) and the start address. Each later word is replayed as a
//   command pair: load the address register (SETA), then write memory (WRIT).
// Ports
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   ser_frame       high for the whole frame (header + data words)
//   ser_din         serial data, MSB first, sampled while ser_frame=1
//   ld_data         io_interface data_in
//   ld_wr_rdb       io_interface wr_rdb
//   ld_addr_memb    io_interface addr_memb
//   ld_instr_datab  io_interface instr_datab
//   busy            frame active or a command pair pending/emitting
//   words_loaded    data words written in the current/last frame (saturating)
//   frame_err       sticky: frame ended on a partial word
module serial_prog_loader #(
    parameter int W        = 16,
    parameter int DATA_AW  = 8,
    parameter int INSTR_AW = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ser_frame,
    input  logic         ser_din,
    output logic [W-1:0] ld_data,
    output logic         ld_wr_rdb,
    output logic         ld_addr_memb,
    output logic         ld_instr_datab,
    output logic         busy,
    output logic [13:0]  words_loaded,
    output logic         frame_err
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SETA = 2'd1,
        WRIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-2:0]        shreg;
    logic [CW-1:0]       bitcnt;
    logic                frame_q;
    logic                hdr_mode;
    logic                tgt;
    logic [INSTR_AW-1:0] ptr;
    logic [W-1:0]        data_buf;
    logic                pend;

    logic                frame_rise, frame_fall;
    logic [CW-1:0]       cnt_eff;
    logic [W-1:0]        word;
    logic                word_done, hdr_done, data_done, wr_exit, pend_next;
    logic [DATA_AW-1:0]  dptr_inc;
    logic [INSTR_AW-1:0] ptr_inc, hdr_ptr;

    logic [W-1:0]        nx_data;
    logic                nx_wr, nx_am, nx_id;

    assign frame_rise = ser_frame & ~frame_q;
    assign frame_fall = ~ser_frame & frame_q;
    // The rising-edge cycle already carries the first header bit, so the
    // count restarts from zero in that same cycle.
    assign cnt_eff    = frame_rise ? '0 : bitcnt;
    assign word       = {shreg, ser_din};
    assign word_done  = ser_frame & (cnt_eff == LAST_BIT);
    assign hdr_done   = word_done & (frame_rise | hdr_mode);
    assign data_done  = word_done & ~(frame_rise | hdr_mode);
    assign wr_exit    = (state == WRIT);
    // A word completing as WRIT exits keeps pend set.
    assign pend_next  = data_done | (pend & ~wr_exit);

    assign dptr_inc = ptr[DATA_AW-1:0] + DATA_AW'(1);
    assign ptr_inc  = tgt ? (ptr + INSTR_AW'(1))
                          : {{(INSTR_AW-DATA_AW){1'b0}}, dptr_inc};
    assign hdr_ptr  = word[W-1] ? word[INSTR_AW-1:0]
                                : {{(INSTR_AW-DATA_AW){1'b0}}, word[DATA_AW-1:0]};

    // Next state and the command values registered onto the port with it.
    always_comb begin
        state_next = state;
        nx_data    = '0;
        nx_wr      = 1'b0;
        nx_am      = 1'b1;
        nx_id      = 1'b0;
        case (state)
            IDLE:    if (pend) state_next = SETA;
            SETA:    state_next = WRIT;
            WRIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (state_next)
            SETA: begin
                nx_wr   = 1'b1;
                nx_am   = 1'b1;
                nx_id   = tgt;
                nx_data = {{(W-INSTR_AW){1'b0}}, ptr};
            end
            WRIT: begin
                nx_wr   = 1'b1;
                nx_am   = 1'b0;
                nx_id   = tgt;
                nx_data = data_buf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg          <= '0;
            bitcnt         <= '0;
            frame_q        <= 1'b0;
            hdr_mode       <= 1'b0;
            tgt            <= 1'b0;
            ptr            <= '0;
            data_buf       <= '0;
            pend           <= 1'b0;
            ld_data        <= '0;
            ld_wr_rdb      <= 1'b0;
            ld_addr_memb   <= 1'b1;
            ld_instr_datab <= 1'b0;
            busy           <= 1'b0;
            words_loaded   <= '0;
            frame_err      <= 1'b0;
        end else begin
            frame_q        <= ser_frame;
            pend           <= pend_next;
            ld_data        <= nx_data;
            ld_wr_rdb      <= nx_wr;
            ld_addr_memb   <= nx_am;
            ld_instr_datab <= nx_id;
            busy           <= ser_frame | pend_next | (state_next != IDLE);

            if (ser_frame) begin
                shreg  <= word[W-2:0];
                bitcnt <= word_done ? '0 : cnt_eff + CW'(1);
            end else if (frame_fall) begin
                bitcnt <= '0;
            end

            if (hdr_done)        hdr_mode <= 1'b0;
            else if (frame_rise) hdr_mode <= 1'b1;

            if (frame_rise)                          frame_err <= 1'b0;
            else if (frame_fall && bitcnt != '0)     frame_err <= 1'b1;

            if (data_done) data_buf <= word;

            if (hdr_done) begin
                tgt <= word[W-1];
                ptr <= hdr_ptr;
            end else if (wr_exit) begin
                ptr <= ptr_inc;
            end

            if (frame_rise)
                words_loaded <= '0;
            else if (wr_exit && words_loaded != '1)
                words_loaded <= words_loaded + 14'd1;
        end
    end

endmodule
